// File: rtl/systolic_feeder.sv
// Skews a 4x4 A/B matrix pair into systolic-array edge streams (rows left, columns top).
// Optional macro SYSTOLIC_FEEDER_ARR_CLEAR_EN adds a one-cycle array-clear state and arr_rst_no.
module systolic_feeder_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int LANE       = 0
) (
    input  logic [3:0]                 step,
    input  logic [3:0][DATA_WIDTH-1:0] vec,
    output logic [DATA_WIDTH-1:0]      q
);
    logic [3:0] diff;

    assign diff = step - 4'(LANE);
    assign q    = (step >= 4'(LANE) && diff < 4'd4) ? vec[diff[1:0]] : '0;
endmodule

module systolic_feeder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic                  wr_sel_i,
    input  logic [3:0]            wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  start_i,
    output logic [DATA_WIDTH-1:0] left_o_0,
    output logic [DATA_WIDTH-1:0] left_o_1,
    output logic [DATA_WIDTH-1:0] left_o_2,
    output logic [DATA_WIDTH-1:0] left_o_3,
    output logic [DATA_WIDTH-1:0] up_o_0,
    output logic [DATA_WIDTH-1:0] up_o_1,
    output logic [DATA_WIDTH-1:0] up_o_2,
    output logic [DATA_WIDTH-1:0] up_o_3,
    output logic                  valid_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef SYSTOLIC_FEEDER_ARR_CLEAR_EN
    ,
    output logic                  arr_rst_no
`endif
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FEED  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef SYSTOLIC_FEEDER_ARR_CLEAR_EN
    localparam logic [2:0] S_CLEAR = 3'd4;
`endif

    logic [2:0] state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       wr_ok;

    logic [15:0][DATA_WIDTH-1:0] a_mem, b_mem, a_nxt, b_nxt;
    logic [3:0][3:0][DATA_WIDTH-1:0] a_row, b_col;
    logic [3:0][DATA_WIDTH-1:0] left_d, up_d, left_q, up_q;

    assign wr_ok = wr_en_i && (state == S_IDLE) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            if (wr_sel_i) b_mem[wr_addr_i] <= wr_data_i;
            else          a_mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Write-through view so a write on the start edge is streamed by that run.
    always_comb begin
        a_nxt = a_mem;
        b_nxt = b_mem;
        if (wr_ok) begin
            if (wr_sel_i) b_nxt[wr_addr_i] = wr_data_i;
            else          a_nxt[wr_addr_i] = wr_data_i;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                cnt_nxt = 4'd0;
`ifdef SYSTOLIC_FEEDER_ARR_CLEAR_EN
                if (start_i) state_nxt = S_CLEAR;
`else
                if (start_i) state_nxt = S_FEED;
`endif
            end
`ifdef SYSTOLIC_FEEDER_ARR_CLEAR_EN
            S_CLEAR: begin
                state_nxt = S_FEED;
                cnt_nxt   = 4'd0;
            end
`endif
            S_FEED: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'd6) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'd10) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            for (gj = 0; gj < 4; gj++) begin : g_tap
                assign a_row[gi][gj] = a_nxt[4*gi+gj];
                assign b_col[gi][gj] = b_nxt[4*gj+gi];
            end
            systolic_feeder_lane #(.DATA_WIDTH(DATA_WIDTH), .LANE(gi)) u_left (
                .step(cnt_nxt), .vec(a_row[gi]), .q(left_d[gi])
            );
            systolic_feeder_lane #(.DATA_WIDTH(DATA_WIDTH), .LANE(gi)) u_up (
                .step(cnt_nxt), .vec(b_col[gi]), .q(up_d[gi])
            );
        end
    endgenerate

    // Data registers are loaded with the step the FSM is about to enter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            left_q <= '0;
            up_q   <= '0;
        end else if (state_nxt == S_FEED) begin
            left_q <= left_d;
            up_q   <= up_d;
        end else begin
            left_q <= '0;
            up_q   <= '0;
        end
    end

    assign left_o_0 = left_q[0];
    assign left_o_1 = left_q[1];
    assign left_o_2 = left_q[2];
    assign left_o_3 = left_q[3];
    assign up_o_0   = up_q[0];
    assign up_o_1   = up_q[1];
    assign up_o_2   = up_q[2];
    assign up_o_3   = up_q[3];
    assign valid_o  = (state == S_FEED);
    assign busy_o   = (state != S_IDLE);
    assign done_o   = (state == S_DONE);
`ifdef SYSTOLIC_FEEDER_ARR_CLEAR_EN
    assign arr_rst_no = (state != S_CLEAR);
`endif
endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized/directed bench for systolic_feeder against a cycle-numbered matrix model.
module tb_systolic_feeder;
    localparam int DW = 32;
`ifdef SYSTOLIC_FEEDER_ARR_CLEAR_EN
    localparam int C = 1;
`else
    localparam int C = 0;
`endif

    logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] l0, l1, l2, l3, u0, u1, u2, u3;
    logic valid, busy, done;
    logic arr_rst;

    logic [DW-1:0] ma [16];
    logic [DW-1:0] mb [16];
    int checks = 0, errors = 0;

    wire [3:0][DW-1:0] lo = {l3, l2, l1, l0};
    wire [3:0][DW-1:0] uo = {u3, u2, u1, u0};

    systolic_feeder #(.DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .start_i(start),
        .left_o_0(l0), .left_o_1(l1), .left_o_2(l2), .left_o_3(l3),
        .up_o_0(u0), .up_o_1(u1), .up_o_2(u2), .up_o_3(u3),
        .valid_o(valid), .busy_o(busy), .done_o(done)
`ifdef SYSTOLIC_FEEDER_ARR_CLEAR_EN
        , .arr_rst_no(arr_rst)
`endif
    );
`ifndef SYSTOLIC_FEEDER_ARR_CLEAR_EN
    assign arr_rst = 1'b1;
`endif

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Element of row r entering the array at step k (skew of r cycles).
    function automatic logic [DW-1:0] exp_left(int r, int k);
        if (k - r >= 0 && k - r <= 3) return ma[4*r + (k - r)];
        return '0;
    endfunction

    function automatic logic [DW-1:0] exp_up(int c, int k);
        if (k - c >= 0 && k - c <= 3) return mb[4*(k - c) + c];
        return '0;
    endfunction

    // t = cycle number counted from the start edge (t=0 means idle).
    task automatic check_cycle(int t);
        bit feed;
        int k;
        feed = (t >= 1 + C) && (t <= 7 + C);
        k    = t - 1 - C;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t%0d left%0d", t, i), lo[i], feed ? exp_left(i, k) : '0);
            chk($sformatf("t%0d up%0d", t, i), uo[i], feed ? exp_up(i, k) : '0);
        end
        chk($sformatf("t%0d valid", t), DW'(valid), DW'(feed));
        chk($sformatf("t%0d busy", t), DW'(busy), DW'((t >= 1) && (t <= 12 + C)));
        chk($sformatf("t%0d done", t), DW'(done), DW'(t == 12 + C));
        chk($sformatf("t%0d arr_rst", t), DW'(arr_rst), DW'(!(C == 1 && t == 1)));
    endtask

    task automatic write_elem(input bit sel, input int addr, input logic [DW-1:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = data;
        tick();
        wr_en = 1'b0;
        if (sel) mb[addr] = data; else ma[addr] = data;
    endtask

    task automatic run(input bit hold_start, input bit wr_at_start, input bit wr_busy);
        if (wr_at_start) begin
            wr_en = 1'b1; wr_sel = 1'($urandom); wr_addr = 4'($urandom); wr_data = $urandom;
            if (wr_sel) mb[wr_addr] = wr_data; else ma[wr_addr] = wr_data;
        end
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        if (!hold_start) start = 1'b0;
        for (int t = 1; t <= 13 + C; t++) begin
            check_cycle(t);
            if (wr_busy && t == 3) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 99;
            end else begin
                wr_en = 1'b0;
            end
            if (t < 13 + C) tick();
        end
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_cycle(0);

        for (int i = 0; i < 16; i++) write_elem(1'b0, i, DW'(i + 1));
        for (int i = 0; i < 16; i++) write_elem(1'b1, i, DW'(i + 17));
        run(1'b0, 1'b0, 1'b0);

        // Write issued mid-run must not land; the next run still sees A[0]=1.
        run(1'b0, 1'b0, 1'b1);
        run(1'b0, 1'b0, 1'b0);

        // start held through the whole run, including DONE.
        run(1'b1, 1'b0, 1'b0);

        // Reset during cycle 4 of a run.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cycle(0);
        tick();
        check_cycle(0);
        run(1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 16; i++) write_elem(1'b0, i, $urandom);
            for (int i = 0; i < 16; i++) write_elem(1'b1, i, $urandom);
            run(1'b0, 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
